// File: rtl/issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : issue_ctrl_pkg
//  Purpose  : Shared definitions for the decode/issue stage. This package holds
//             the RV32 base opcodes, the instruction field positions, the
//             register-use classification and the issue FSM state encoding.
//             The instruction decoder uses the same definitions.
//  Revision : 1.0  initial release
// ============================================================================
package issue_ctrl_pkg;

    localparam int REG_W   = 5;
    localparam int NREG    = 32;

    // Bit positions of the instruction fields
    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 7;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic wr_rd;
    } reg_use_t;

    // Unknown opcodes read and write nothing, so they never interlock.
    function automatic reg_use_t classify(input logic [6:0] opc);
        reg_use_t u;
        u = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_rd: 1'b0};
        case (opc)
            OP_R:                      u = '{use_rs1: 1'b1, use_rs2: 1'b1, wr_rd: 1'b1};
            OP_IMM, OP_LOAD, OP_JALR:  u = '{use_rs1: 1'b1, use_rs2: 1'b0, wr_rd: 1'b1};
            OP_STORE, OP_BRANCH:       u = '{use_rs1: 1'b1, use_rs2: 1'b1, wr_rd: 1'b0};
            OP_LUI, OP_AUIPC, OP_JAL:  u = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_rd: 1'b1};
            default:                   u = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_rd: 1'b0};
        endcase
        return u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : issue_ctrl_scoreboard
//  Purpose  : Register scoreboard. It holds one busy bit per architectural
//             register.
//  Ports    : clk, rst_n      clock, synchronous active-low reset
//             i_set_en/idx    mark a register busy (issue of a writer)
//             i_clr_en/idx    release a register (writeback)
//             o_busy          busy vector; bit 0 is tied to 0
//  Revision : 1.0  initial release
// ============================================================================
module issue_ctrl_scoreboard
    import issue_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_set_en,
    input  logic [REG_W-1:0] i_set_idx,
    input  logic             i_clr_en,
    input  logic [REG_W-1:0] i_clr_idx,
    output logic [NREG-1:0]  o_busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_next;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_set_en) w_set[i_set_idx] = 1'b1;
        if (i_clr_en) w_clr[i_clr_idx] = 1'b1;
        // A set wins over a clear of the same register. The new writer was
        // issued after the retiring one.
        w_next    = (r_busy & ~w_clr) | w_set;
        w_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_next;
    end

    assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : issue_ctrl
//  Purpose  : Decode/issue scheduler. It owns the IF/ID register and
//             interlocks RAW/WAW hazards through a register scoreboard. It
//             flushes on redirect and counts stall cycles with saturation.
//  Ports    : clk, rst_n               clock, synchronous active-low reset
//             if_valid/if_inst/if_pc   fetch side input
//             if_ready                 IF/ID can accept this cycle
//             id_valid/id_inst/id_pc   offer to execute
//             id_ready                 execute accepts
//             wb_valid/wb_rd           writeback release
//             flush                    control redirect
//             stall, busy_map, stall_cnt  status
//  Revision : 1.0  initial release
// ============================================================================
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_inst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_ready,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_inst,
    output logic [XLEN-1:0]  id_pc,
    input  logic             id_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic             stall,
    output logic [31:0]      busy_map,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t           r_state;
    logic [XLEN-1:0]  r_inst;
    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;

    reg_use_t         w_use;
    logic [REG_W-1:0] w_rs1;
    logic [REG_W-1:0] w_rs2;
    logic [REG_W-1:0] w_rd;
    logic             w_full;
    logic             w_hazard;
    logic             w_issue;
    logic             w_accept;
    logic [NREG-1:0]  w_busy;

    assign w_use  = classify(r_inst[OPC_LSB +: OPC_W]);
    assign w_rs1  = r_inst[RS1_LSB +: REG_W];
    assign w_rs2  = r_inst[RS2_LSB +: REG_W];
    assign w_rd   = r_inst[RD_LSB  +: REG_W];
    assign w_full = (r_state == ST_FULL);

    // The scoreboard never marks x0 busy, so x0 operands cannot hazard.
    // The hazard uses the registered busy vector. A writeback releases
    // the stall one cycle later.
    assign w_hazard = w_full &&
                      ((w_use.use_rs1 && w_busy[w_rs1]) ||
                       (w_use.use_rs2 && w_busy[w_rs2]) ||
                       (w_use.wr_rd   && w_busy[w_rd]));

    assign id_valid = w_full && !w_hazard;
    assign stall    = w_hazard;
    assign w_issue  = id_valid && id_ready;
    assign if_ready = !flush && (!w_full || w_issue);
    assign w_accept = if_valid && if_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_inst  <= '0;
            r_pc    <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                        r_inst  <= if_inst;
                        r_pc    <= if_pc;
                    end
                end
                ST_FULL: begin
                    if (flush) begin
                        r_state <= ST_EMPTY;
                    end else if (w_issue && w_accept) begin
                        r_inst  <= if_inst;
                        r_pc    <= if_pc;
                    end else if (w_issue) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
            // flush takes priority in every state. if_ready is already low,
            // so no fetch is captured in the flush cycle.
            if (flush) r_state <= ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                   r_cnt <= '0;
        else if (w_hazard && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end

    // An instruction issued in a flush cycle is discarded and never writes
    // back. It must not reserve its destination register.
    issue_ctrl_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set_en  (w_issue && w_use.wr_rd && !flush),
        .i_set_idx (w_rd),
        .i_clr_en  (wb_valid),
        .i_clr_idx (wb_rd),
        .o_busy    (w_busy)
    );

    assign id_inst   = r_inst;
    assign id_pc     = r_pc;
    assign busy_map  = w_busy;
    assign stall_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_ctrl
//  Purpose  : Directed testbench for issue_ctrl. It checks reset, independent
//             issue, RAW and store interlocks, flush, set/clear priority and
//             stall counter saturation on a CNT_W=4 copy.
//  Revision : 1.0  initial release
// ============================================================================
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;

    logic        if_ready,  id_valid,  stall;
    logic [31:0] id_inst,   id_pc,     busy_map, stall_cnt;
    logic        if_ready4, id_valid4, stall4;
    logic [31:0] id_inst4,  id_pc4,    busy_map4;
    logic [3:0]  stall_cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    issue_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_ready(if_ready), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .id_ready(id_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .stall(stall), .busy_map(busy_map), .stall_cnt(stall_cnt)
    );

    issue_ctrl #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_ready(if_ready4), .id_valid(id_valid4), .id_inst(id_inst4), .id_pc(id_pc4),
        .id_ready(id_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .stall(stall4), .busy_map(busy_map4), .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge. Inputs change here, and
    // checks run 1ns later, away from both edges.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0;
        id_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        tick(); tick();
        settle();
        chk("rst_busy",     busy_map,  32'h0);
        chk("rst_cnt",      stall_cnt, 32'h0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_if_ready", {31'b0, if_ready}, 32'h1);
        chk("rst_stall",    {31'b0, stall},    32'h0);
        rst_n = 1'b1;
        tick();

        // ---- independent: addi x1,x0,5 ; lui x5,1 ----
        if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 32'h100;
        settle();
        chk("ind_if_ready", {31'b0, if_ready}, 32'h1);
        tick();
        if_inst = 32'h000012B7; if_pc = 32'h104;
        settle();
        chk("ind_v0",    {31'b0, id_valid}, 32'h1);
        chk("ind_inst0", id_inst, 32'h00500093);
        chk("ind_pc0",   id_pc,   32'h100);
        tick();
        if_valid = 1'b0;
        settle();
        chk("ind_v1",    {31'b0, id_valid}, 32'h1);
        chk("ind_inst1", id_inst, 32'h000012B7);
        chk("ind_pc1",   id_pc,   32'h104);
        tick();
        settle();
        chk("ind_busy",  busy_map, 32'h00000022);
        chk("ind_empty", {31'b0, id_valid}, 32'h0);
        wb_valid = 1'b1; wb_rd = 5'd1; tick();
        wb_rd = 5'd5; tick();
        wb_valid = 1'b0;
        settle();
        chk("ind_clr", busy_map, 32'h0);

        // ---- RAW: addi x1 ; add x2,x1,x1 ----
        if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 32'h200;
        tick();
        if_inst = 32'h00108133; if_pc = 32'h204;
        tick();
        if_valid = 1'b0;
        settle();
        chk("raw_stall",    {31'b0, stall},    32'h1);
        chk("raw_id_valid", {31'b0, id_valid}, 32'h0);
        chk("raw_if_ready", {31'b0, if_ready}, 32'h0);
        chk("raw_cnt0",     stall_cnt, 32'd0);
        tick();
        chk("raw_cnt1", stall_cnt, 32'd1);
        tick();
        chk("raw_cnt2", stall_cnt, 32'd2);
        wb_valid = 1'b1; wb_rd = 5'd1;
        settle();
        chk("raw_nobypass", {31'b0, stall}, 32'h1);
        tick();
        wb_valid = 1'b0;
        settle();
        chk("raw_release", {31'b0, id_valid}, 32'h1);
        chk("raw_inst",    id_inst,   32'h00108133);
        chk("raw_cnt3",    stall_cnt, 32'd3);
        tick();
        settle();
        chk("raw_busy", busy_map, 32'h00000004);

        // ---- load/store: lw x3,0(x1) ; sw x1,0(x2) with x2 busy ----
        if_valid = 1'b1; if_inst = 32'h0000A183; if_pc = 32'h300;
        tick();
        if_inst = 32'h00112023; if_pc = 32'h304;
        settle();
        chk("lw_valid", {31'b0, id_valid}, 32'h1);
        tick();
        if_valid = 1'b0;
        settle();
        chk("sw_stall", {31'b0, stall}, 32'h1);
        chk("sw_inst",  id_inst,  32'h00112023);
        chk("ls_busy",  busy_map, 32'h0000000C);
        tick();
        wb_valid = 1'b1; wb_rd = 5'd2;
        tick();
        wb_valid = 1'b0;
        settle();
        chk("sw_release", {31'b0, id_valid}, 32'h1);
        chk("sw_cnt",     stall_cnt, 32'd5);
        tick();
        settle();
        chk("sw_busy",  busy_map, 32'h00000008);
        chk("sw_empty", {31'b0, id_valid}, 32'h0);
        wb_valid = 1'b1; wb_rd = 5'd3; tick();
        wb_valid = 1'b0;

        // ---- flush while FULL with a fetch pending ----
        id_ready = 1'b0;
        if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 32'h400;
        tick();
        flush = 1'b1; if_inst = 32'h000012B7; if_pc = 32'h404;
        settle();
        chk("fl_if_ready", {31'b0, if_ready}, 32'h0);
        tick();
        flush = 1'b0; if_valid = 1'b0;
        settle();
        chk("fl_id_valid", {31'b0, id_valid}, 32'h0);
        chk("fl_if_ready2", {31'b0, if_ready}, 32'h1);
        chk("fl_busy", busy_map, 32'h0);
        tick();
        chk("fl_still_empty", {31'b0, id_valid}, 32'h0);
        id_ready = 1'b1;

        // ---- issue of x7 writer with same-cycle writeback to x7 ----
        if_valid = 1'b1; if_inst = 32'h00500393; if_pc = 32'h500;
        tick();
        if_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd7;
        tick();
        wb_valid = 1'b0;
        settle();
        chk("setwin_busy", busy_map, 32'h00000080);
        wb_valid = 1'b1; wb_rd = 5'd0;
        tick();
        wb_valid = 1'b0;
        settle();
        chk("wb_x0", busy_map, 32'h00000080);

        // ---- long stall on x7: add x8,x7,x7; CNT_W=4 copy saturates ----
        if_valid = 1'b1; if_inst = 32'h00738433; if_pc = 32'h600;
        tick();
        if_valid = 1'b0;
        settle();
        chk("sat_stall", {31'b0, stall}, 32'h1);
        chk("sat_cnt5",  stall_cnt, 32'd5);
        for (int i = 0; i < 12; i++) tick();
        chk("cnt32_17", stall_cnt, 32'd17);
        chk("cnt4_sat", {28'b0, stall_cnt4}, 32'd15);
        tick();
        chk("cnt4_hold", {28'b0, stall_cnt4}, 32'd15);
        chk("cnt32_18",  stall_cnt, 32'd18);
        flush = 1'b1; tick();
        flush = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd7; tick();
        wb_valid = 1'b0;
        settle();
        chk("end_busy",  busy_map, 32'h0);
        chk("end_empty", {31'b0, id_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
